// File: rtl/super_hub_pkg.sv
// super_hub_pkg: shared types and constants for the super-hub merge block.
//   FLIT_W     flit width (dest_local lives in flit[1:0])
//   NUM_CHILD  number of child cluster routers feeding the hub
//   flit_t     one flit
//   child_idx_t index of a child port
package super_hub_pkg;
  localparam int FLIT_W    = 20;
  localparam int NUM_CHILD = 4;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [1:0]        child_idx_t;
endpackage

// File: rtl/hub_flit_fifo.sv
// hub_flit_fifo: synchronous FIFO, DEPTH x W, one per child port.
//   clk, rst   clock, async active-high reset (pointers/count only)
//   push, din  write request and data; dropped when full
//   pop        read request; ignored when empty
//   head       entry at the read pointer (valid while !empty)
//   full/empty occupancy flags
//   ovf        1-cycle pulse: push attempted while full
// Fullness is judged on the pre-edge count, so a push to a full FIFO is
// dropped even when the same FIFO pops in that cycle.
module hub_flit_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             cnt;
  logic                    do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign ovf     = push && full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: empty flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/super_hub_merge.sv
// super_hub_merge: merges flits from four child cluster routers into one
// stream toward crossbar port o4. Per-child FIFO, round-robin arbitration,
// credit flow control toward children (cred_child) and upstream (cred_up).
//   clk, rst          clock, async active-high reset
//   in_cluster0..3    child flits, qualified by v_cluster0..3
//   cred_child[3:0]   1-cycle credit return pulse per child
//   sd_out/_valid     registered merged flit, 1-cycle valid pulse
//   cred_up           upstream freed one slot
//   ovf_err           sticky: a child wrote into a full FIFO
// Optional build macro SUPER_HUB_SRC_TAG_EN: sd_out[1:0] carries the granted
// child index instead of the flit's own low bits.
module super_hub_merge
  import super_hub_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int UP_CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  flit_t                in_cluster0,
  input  flit_t                in_cluster1,
  input  flit_t                in_cluster2,
  input  flit_t                in_cluster3,
  input  logic                 v_cluster0,
  input  logic                 v_cluster1,
  input  logic                 v_cluster2,
  input  logic                 v_cluster3,
  output logic [NUM_CHILD-1:0] cred_child,
  output flit_t                sd_out,
  output logic                 sd_out_valid,
  input  logic                 cred_up,
  output logic                 ovf_err
);
  logic [NUM_CHILD-1:0][FLIT_W-1:0] din, head;
  logic [NUM_CHILD-1:0]             push, pop, full, empty, ovf, elig;
  logic [NUM_CHILD-1:0]             pop_q;
  logic [3:0]                       up_cnt;
  child_idx_t                       rr_ptr, gnt_idx;
  logic                             gnt_vld;
  flit_t                            out_flit;

  assign din  = {in_cluster3, in_cluster2, in_cluster1, in_cluster0};
  assign push = {v_cluster3, v_cluster2, v_cluster1, v_cluster0};

  for (genvar i = 0; i < NUM_CHILD; i++) begin : g_fifo
    hub_flit_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (din[i]),
      .pop   (pop[i]),
      .head  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .ovf   (ovf[i])
    );
  end

  // No upstream credit means nobody is eligible, so no grant at up_cnt=0.
  assign elig = ~empty & {NUM_CHILD{up_cnt != 4'd0}};

  // Round-robin search starting at rr_ptr; the 2-bit add wraps 3->0.
  always_comb begin
    child_idx_t idx;
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr;
    idx     = rr_ptr;
    for (int k = 0; k < NUM_CHILD; k++) begin
      idx = rr_ptr + child_idx_t'(k);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign pop = gnt_vld ? (NUM_CHILD'(1) << gnt_idx) : '0;

`ifdef SUPER_HUB_SRC_TAG_EN
  assign out_flit = {head[gnt_idx][FLIT_W-1:2], gnt_idx};
`else
  assign out_flit = head[gnt_idx];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      up_cnt       <= 4'(UP_CREDITS);
      sd_out       <= '0;
      sd_out_valid <= 1'b0;
      pop_q        <= '0;
      cred_child   <= '0;
      ovf_err      <= 1'b0;
    end else begin
      sd_out_valid <= gnt_vld;
      if (gnt_vld) begin
        sd_out <= out_flit;
        rr_ptr <= gnt_idx + 1'b1;
      end
      // Credit goes back to the child one cycle after the flit leaves.
      pop_q      <= pop;
      cred_child <= pop_q;
      // Grant and cred_up together cancel; cred_up beyond the limit is lost.
      if (gnt_vld && !cred_up)
        up_cnt <= up_cnt - 1'b1;
      else if (cred_up && !gnt_vld && up_cnt != 4'(UP_CREDITS))
        up_cnt <= up_cnt + 1'b1;
      if (|ovf) ovf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_super_hub_merge.sv
// tb_super_hub_merge: directed self-checking bench for super_hub_merge.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_super_hub_merge;
  import super_hub_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  flit_t      in_cluster0, in_cluster1, in_cluster2, in_cluster3;
  logic       v_cluster0, v_cluster1, v_cluster2, v_cluster3;
  logic [3:0] cred_child;
  flit_t      sd_out;
  logic       sd_out_valid;
  logic       cred_up;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;

`ifdef SUPER_HUB_SRC_TAG_EN
  localparam flit_t EXP1 = 20'hABCD2;
`else
  localparam flit_t EXP1 = 20'hABCD1;
`endif

  super_hub_merge #(.FIFO_DEPTH(4), .UP_CREDITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_cluster0  (in_cluster0),
    .in_cluster1  (in_cluster1),
    .in_cluster2  (in_cluster2),
    .in_cluster3  (in_cluster3),
    .v_cluster0   (v_cluster0),
    .v_cluster1   (v_cluster1),
    .v_cluster2   (v_cluster2),
    .v_cluster3   (v_cluster3),
    .cred_child   (cred_child),
    .sd_out       (sd_out),
    .sd_out_valid (sd_out_valid),
    .cred_up      (cred_up),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task clear_inputs;
    in_cluster0 = '0; in_cluster1 = '0; in_cluster2 = '0; in_cluster3 = '0;
    v_cluster0 = 0; v_cluster1 = 0; v_cluster2 = 0; v_cluster3 = 0;
    cred_up = 0;
  endtask

  task push(input int c, input flit_t f);
    case (c)
      0: begin in_cluster0 = f; v_cluster0 = 1; end
      1: begin in_cluster1 = f; v_cluster1 = 1; end
      2: begin in_cluster2 = f; v_cluster2 = 1; end
      default: begin in_cluster3 = f; v_cluster3 = 1; end
    endcase
  endtask

  task apply_reset;
    @(negedge clk); rst = 1; clear_inputs;
    @(negedge clk); rst = 0;
  endtask

  // Spend all four upstream credits through child 0.
  task drain_credits;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); clear_inputs; push(0, flit_t'(20'h0F000 + k * 16));
    end
    @(negedge clk); clear_inputs;
    repeat (6) @(negedge clk);
  endtask

  task test_reset;
    clear_inputs;
    #2 rst = 1;
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sd_out_valid); end
    checks++; if (sd_out !== 20'h0) begin errors++; $display("FAIL reset_sd_out: got %h want 00000", sd_out); end
    checks++; if (cred_child !== 4'b0) begin errors++; $display("FAIL reset_cred: got %b want 0000", cred_child); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
    checks++; if (dut.up_cnt !== 4'd4) begin errors++; $display("FAIL reset_up_cnt: got %0d want 4", dut.up_cnt); end
    @(negedge clk); rst = 0;
  endtask

  task test_single;
    apply_reset;
    @(negedge clk); push(2, 20'hABCD1);
    @(negedge clk); clear_inputs;
    checks++; if (sd_out_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid %b want 0", sd_out_valid); end
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", sd_out_valid); end
    checks++; if (sd_out !== EXP1) begin errors++; $display("FAIL single_data: got %h want %h", sd_out, EXP1); end
    checks++; if (cred_child !== 4'b0000) begin errors++; $display("FAIL single_cred_early: got %b want 0000", cred_child); end
    @(negedge clk);
    checks++; if (cred_child !== 4'b0100) begin errors++; $display("FAIL single_cred: got %b want 0100", cred_child); end
    checks++; if (sd_out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: valid %b want 0", sd_out_valid); end
    @(negedge clk);
    checks++; if (cred_child !== 4'b0000) begin errors++; $display("FAIL single_cred_end: got %b want 0000", cred_child); end
  endtask

  task test_round_robin;
    flit_t exp;
    apply_reset;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(i, flit_t'(((i + 1) << 16) | i));
    @(negedge clk); clear_inputs;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = flit_t'(((i + 1) << 16) | i);
      checks++; if (sd_out_valid !== 1'b1 || sd_out !== exp) begin
        errors++; $display("FAIL rr_order%0d: got v=%b %h want v=1 %h", i, sd_out_valid, sd_out, exp);
      end
    end
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: valid %b want 0", sd_out_valid); end
    // Refill credits, then contend children 3 and 0: pointer wrapped to 0.
    cred_up = 1;
    repeat (4) @(negedge clk);
    cred_up = 0;
    push(3, 20'h7A003); push(0, 20'h7B000);
    @(negedge clk); clear_inputs;
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b1 || sd_out !== 20'h7B000) begin
      errors++; $display("FAIL rr_wrap_first: got v=%b %h want v=1 7b000", sd_out_valid, sd_out);
    end
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b1 || sd_out !== 20'h7A003) begin
      errors++; $display("FAIL rr_wrap_second: got v=%b %h want v=1 7a003", sd_out_valid, sd_out);
    end
  endtask

  task test_up_credits;
    int    outs;
    flit_t last;
    apply_reset;
    outs = 0; last = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (sd_out_valid) begin outs++; last = sd_out; end
      clear_inputs;
      if (c < 6) push(0, flit_t'(20'h30000 + c * 16));
    end
    checks++; if (outs != 4) begin errors++; $display("FAIL credit_limit: got %0d outputs want 4", outs); end
    checks++; if (last !== 20'h30030) begin errors++; $display("FAIL credit_last: got %h want 30030", last); end
    checks++; if (dut.up_cnt !== 4'd0) begin errors++; $display("FAIL credit_zero: up_cnt %0d want 0", dut.up_cnt); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL credit_no_ovf: got %b want 0", ovf_err); end
    @(negedge clk); cred_up = 1;
    outs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); cred_up = 0;
      if (sd_out_valid) begin outs++; last = sd_out; end
    end
    checks++; if (outs != 1) begin errors++; $display("FAIL credit_one_more: got %0d outputs want 1", outs); end
    checks++; if (last !== 20'h30040) begin errors++; $display("FAIL credit_one_data: got %h want 30040", last); end
  endtask

  task test_overflow;
    int    outs;
    flit_t exp;
    apply_reset;
    drain_credits;
    checks++; if (dut.up_cnt !== 4'd0) begin errors++; $display("FAIL ovf_drained: up_cnt %0d want 0", dut.up_cnt); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", ovf_err); end
      end
      clear_inputs; push(1, flit_t'(20'h40001 + k * 16));
    end
    @(negedge clk); clear_inputs;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
    checks++; if (sd_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_out: valid %b want 0", sd_out_valid); end
    outs = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (sd_out_valid) begin
        exp = flit_t'(20'h40001 + outs * 16);
        checks++; if (sd_out !== exp) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", outs, sd_out, exp); end
        outs++;
      end
      cred_up = (c < 8);
    end
    cred_up = 0;
    checks++; if (outs != 4) begin errors++; $display("FAIL ovf_count: got %0d outputs want 4", outs); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
  endtask

  task test_coincide;
    apply_reset;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); clear_inputs; push(0, flit_t'(20'h0E000 + k * 16));
    end
    @(negedge clk); clear_inputs;
    repeat (6) @(negedge clk);
    checks++; if (dut.up_cnt !== 4'd1) begin errors++; $display("FAIL coin_setup: up_cnt %0d want 1", dut.up_cnt); end
    push(2, 20'h50002);
    @(negedge clk); clear_inputs; push(2, 20'h50012); cred_up = 1;
    @(negedge clk); clear_inputs;
    checks++; if (dut.up_cnt !== 4'd1) begin errors++; $display("FAIL coin_hold: up_cnt %0d want 1", dut.up_cnt); end
    checks++; if (sd_out_valid !== 1'b1 || sd_out !== 20'h50002) begin
      errors++; $display("FAIL coin_first: got v=%b %h want v=1 50002", sd_out_valid, sd_out);
    end
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b1 || sd_out !== 20'h50012) begin
      errors++; $display("FAIL coin_next: got v=%b %h want v=1 50012", sd_out_valid, sd_out);
    end
    checks++; if (dut.up_cnt !== 4'd0) begin errors++; $display("FAIL coin_spent: up_cnt %0d want 0", dut.up_cnt); end
  endtask

  task test_reset_mid;
    int outs, creds;
    apply_reset;
    drain_credits;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); clear_inputs; push(3, flit_t'(20'h60003 + k * 16));
    end
    @(negedge clk); clear_inputs;
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b0) begin errors++; $display("FAIL mid_stuck: valid %b want 0", sd_out_valid); end
    rst = 1;
    #1;
    checks++; if (dut.up_cnt !== 4'd4) begin errors++; $display("FAIL mid_up_cnt: got %0d want 4", dut.up_cnt); end
    @(negedge clk);
    checks++; if (sd_out_valid !== 1'b0 || cred_child !== 4'b0) begin
      errors++; $display("FAIL mid_outputs: valid %b cred %b want 0 0000", sd_out_valid, cred_child);
    end
    rst = 0;
    outs = 0; creds = 0;
    repeat (10) begin
      @(negedge clk);
      if (sd_out_valid) outs++;
      if (cred_child != 4'b0) creds++;
    end
    checks++; if (outs != 0) begin errors++; $display("FAIL mid_stale_flits: got %0d want 0", outs); end
    checks++; if (creds != 0) begin errors++; $display("FAIL mid_stale_creds: got %0d want 0", creds); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_up_credits;
    test_overflow;
    test_coincide;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
